// File: rtl/uart_pkg.sv
// Shared types for the UART receive path: controller states, FIFO entry layout
// and the receiver's baud constant.
package uart_pkg;

    localparam int CLKS_PER_BAUD = 1250;

    typedef enum logic [1:0] {
        IDLE,
        LISTEN,
        FULL
    } rx_ctrl_state_t;

    typedef struct packed {
        logic       err;
        logic [7:0] data;
    } rx_entry_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a separately tracked occupancy count and a
// combinational head read that returns zero when empty.
module sync_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         nRst,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         clr,
    input  logic [WIDTH-1:0]             wr_data,
    output logic [WIDTH-1:0]             rd_data,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop & ~empty;
    // A pop in the same cycle frees the slot the push writes into.
    assign do_push = push & (~full | do_pop);
    assign rd_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// Receive-side controller: gates uart_rx via rec_ready_o, buffers completed
// bytes with their parity flag and reports overrun, parity errors and idle timeout.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int DEPTH          = 4,
    parameter int TIMEOUT_CYCLES = 12500
) (
    input  logic                       clk,
    input  logic                       nRst,
    input  logic                       en,
    input  logic                       clr,
    input  logic                       rx_ready_i,
    input  logic [7:0]                 rx_byte_i,
    input  logic                       parity_err_i,
    output logic                       rec_ready_o,
    input  logic                       pop,
    output logic [7:0]                 rd_data,
    output logic                       rd_err,
    output logic                       rd_valid,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overrun,
    output logic [7:0]                 err_count,
    output logic                       timeout
);

    localparam int CW = $clog2(DEPTH+1);
    localparam int TW = $clog2(TIMEOUT_CYCLES);

    rx_ctrl_state_t state;
    logic           rx_q;
    logic           push_q;
    rx_entry_t      entry_q;
    rx_entry_t      head;
    logic [TW-1:0]  idle_cnt;

    logic           fifo_full;
    logic           fifo_empty;
    logic           pop_ok;
    logic           push_ok;
    logic           drop;
    logic [CW-1:0]  count_nxt;

    sync_fifo #(
        .WIDTH ($bits(rx_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .nRst    (nRst),
        .push    (push_ok),
        .pop     (pop_ok),
        .clr     (clr),
        .wr_data (entry_q),
        .rd_data (head),
        .count   (count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign rd_valid = ~fifo_empty;
    assign rd_data  = head.data;
    assign rd_err   = head.err;

    assign pop_ok    = pop & ~fifo_empty & ~clr;
    assign push_ok   = push_q & ~clr & (~fifo_full | pop_ok);
    assign drop      = push_q & ~clr & fifo_full & ~pop_ok;
    assign count_nxt = clr ? '0 : count + CW'(push_ok) - CW'(pop_ok);

    // The rising edge is captured together with the byte one cycle before it
    // reaches the FIFO, so the write stage sees a stable, qualified entry.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            rx_q    <= 1'b0;
            push_q  <= 1'b0;
            entry_q <= '0;
        end else begin
            rx_q    <= rx_ready_i;
            push_q  <= rx_ready_i & ~rx_q & en;
            entry_q <= '{err: parity_err_i, data: rx_byte_i};
        end
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state       <= IDLE;
            rec_ready_o <= 1'b0;
            overrun     <= 1'b0;
            err_count   <= '0;
        end else begin
            if (!en) begin
                state <= IDLE;
            end else if (count_nxt == CW'(DEPTH)) begin
                state <= FULL;
            end else begin
                state <= LISTEN;
            end
            rec_ready_o <= (state == LISTEN);

            if (clr) begin
                overrun   <= 1'b0;
                err_count <= '0;
            end else begin
                if (drop) begin
                    overrun <= 1'b1;
                end
                // Dropped bytes still count toward the parity statistics.
                if (push_q && entry_q.err) begin
                    err_count <= sat_inc8(err_count);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            idle_cnt <= '0;
            timeout  <= 1'b0;
        end else if (clr || push_q || pop_ok || fifo_empty) begin
            idle_cnt <= '0;
            timeout  <= 1'b0;
        end else if (idle_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
            idle_cnt <= '0;
            timeout  <= 1'b1;
        end else begin
            idle_cnt <= idle_cnt + TW'(1);
            timeout  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: vector table, directed corner cases
// and randomized traffic checked against a queue-based reference model.
module tb_uart_rx_ctrl;

    localparam int DEPTH = 4;
    localparam int TO    = 12500;

    logic       clk = 1'b0;
    logic       nRst;
    logic       en;
    logic       clr;
    logic       rx_ready_i;
    logic [7:0] rx_byte_i;
    logic       parity_err_i;
    logic       pop;
    logic       rec_ready_o;
    logic [7:0] rd_data;
    logic       rd_err;
    logic       rd_valid;
    logic [2:0] count;
    logic       overrun;
    logic [7:0] err_count;
    logic       timeout;

    int n_checks = 0;
    int n_fail   = 0;

    uart_rx_ctrl #(
        .DEPTH          (DEPTH),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk          (clk),
        .nRst         (nRst),
        .en           (en),
        .clr          (clr),
        .rx_ready_i   (rx_ready_i),
        .rx_byte_i    (rx_byte_i),
        .parity_err_i (parity_err_i),
        .rec_ready_o  (rec_ready_o),
        .pop          (pop),
        .rd_data      (rd_data),
        .rd_err       (rd_err),
        .rd_valid     (rd_valid),
        .count        (count),
        .overrun      (overrun),
        .err_count    (err_count),
        .timeout      (timeout)
    );

    always #5 clk = ~clk;

    // Reference model: FIFO contents as a queue, plus a one-cycle pending push.
    logic [8:0] mq[$];
    bit         m_ovr;
    int         m_err;
    bit         m_pend;
    logic [8:0] m_pend_e;
    bit         m_prev;
    bit         m_listen;
    bit         m_rr;

    typedef struct {
        bit         rx;
        logic [7:0] b;
        bit         pop;
        bit         clr;
        int         exp_count;
        bit         exp_valid;
        logic [7:0] exp_data;
        bit         exp_ovr;
        bit         exp_rr;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_ovr    = 0;
        m_err    = 0;
        m_pend   = 0;
        m_pend_e = '0;
        m_prev   = 0;
        m_listen = 0;
        m_rr     = 0;
    endtask

    task automatic model_edge();
        bit popped;
        if (!nRst) begin
            model_reset();
            return;
        end
        popped = pop && (mq.size() > 0) && !clr;
        if (clr) begin
            mq.delete();
            m_ovr = 0;
            m_err = 0;
        end else begin
            if (popped) void'(mq.pop_front());
            if (m_pend) begin
                if (mq.size() < DEPTH) mq.push_back(m_pend_e);
                else m_ovr = 1;
                if (m_pend_e[8] && m_err < 255) m_err = m_err + 1;
            end
        end
        m_rr     = m_listen;
        m_listen = en && (mq.size() < DEPTH);
        m_pend   = rx_ready_i && !m_prev && en;
        m_pend_e = {parity_err_i, rx_byte_i};
        m_prev   = rx_ready_i;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic apply_stimulus(input bit e, input bit c, input bit r,
                                  input logic [7:0] b, input bit p, input bit pp);
        en           = e;
        clr          = c;
        rx_ready_i   = r;
        rx_byte_i    = b;
        parity_err_i = p;
        pop          = pp;
    endtask

    task automatic push_byte(input logic [7:0] b, input bit p);
        rx_ready_i   = 1'b1;
        rx_byte_i    = b;
        parity_err_i = p;
        step();
        rx_ready_i   = 1'b0;
        step();
    endtask

    task automatic do_pop();
        pop = 1'b1;
        step();
        pop = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_rec_ready"}, 32'(rec_ready_o), 32'd0);
        check({tag, "_rd_valid"},  32'(rd_valid),    32'd0);
        check({tag, "_rd_data"},   32'(rd_data),     32'd0);
        check({tag, "_rd_err"},    32'(rd_err),      32'd0);
        check({tag, "_count"},     32'(count),       32'd0);
        check({tag, "_overrun"},   32'(overrun),     32'd0);
        check({tag, "_err_count"}, 32'(err_count),   32'd0);
        check({tag, "_timeout"},   32'(timeout),     32'd0);
    endtask

    task automatic check_output();
        logic [8:0] h;
        h = (mq.size() > 0) ? mq[0] : 9'd0;
        check("mdl_rd_valid",  32'(rd_valid),    32'(mq.size() > 0));
        check("mdl_count",     32'(count),       32'(mq.size()));
        check("mdl_rd_data",   32'(rd_data),     32'(h[7:0]));
        check("mdl_rd_err",    32'(rd_err),      32'(h[8]));
        check("mdl_overrun",   32'(overrun),     32'(m_ovr));
        check("mdl_err_count", 32'(err_count),   32'(m_err));
        check("mdl_rec_ready", 32'(rec_ready_o), 32'(m_rr));
    endtask

    initial begin
        #900000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int         k;
        bit         saw;
        logic [7:0] exp_q[4];
        bit         exp_e[4];

        vecs[0]  = '{1, 8'h01, 0, 0, 0, 0, 8'h00, 0, 1};
        vecs[1]  = '{0, 8'h00, 0, 0, 1, 1, 8'h01, 0, 1};
        vecs[2]  = '{1, 8'h02, 0, 0, 1, 1, 8'h01, 0, 1};
        vecs[3]  = '{0, 8'h00, 0, 0, 2, 1, 8'h01, 0, 1};
        vecs[4]  = '{1, 8'h03, 0, 0, 2, 1, 8'h01, 0, 1};
        vecs[5]  = '{0, 8'h00, 0, 0, 3, 1, 8'h01, 0, 1};
        vecs[6]  = '{1, 8'h04, 0, 0, 3, 1, 8'h01, 0, 1};
        vecs[7]  = '{0, 8'h00, 0, 0, 4, 1, 8'h01, 0, 1};
        vecs[8]  = '{1, 8'h05, 0, 0, 4, 1, 8'h01, 0, 0};
        vecs[9]  = '{0, 8'h00, 0, 0, 4, 1, 8'h01, 1, 0};
        vecs[10] = '{0, 8'h00, 1, 0, 3, 1, 8'h02, 1, 0};
        vecs[11] = '{0, 8'h00, 1, 0, 2, 1, 8'h03, 1, 1};
        vecs[12] = '{0, 8'h00, 1, 0, 1, 1, 8'h04, 1, 1};
        vecs[13] = '{0, 8'h00, 1, 0, 0, 0, 8'h00, 1, 1};
        vecs[14] = '{0, 8'h00, 1, 0, 0, 0, 8'h00, 1, 1};
        vecs[15] = '{0, 8'h00, 0, 1, 0, 0, 8'h00, 0, 1};

        nRst = 1'b1;
        apply_stimulus(0, 0, 0, 8'h00, 0, 0);
        model_reset();
        #1 nRst = 1'b0;
        repeat (3) step();
        check_reset_values("reset");
        nRst = 1'b1;

        repeat (3) step();
        check("idle_rec_ready", 32'(rec_ready_o), 32'd0);
        en = 1'b1;
        step();
        check("en_rec_ready_lag", 32'(rec_ready_o), 32'd0);
        step();
        check("en_rec_ready", 32'(rec_ready_o), 32'd1);

        clr = 1'b1;
        step();
        clr = 1'b0;
        for (int i = 0; i < 16; i++) begin
            apply_stimulus(1, vecs[i].clr, vecs[i].rx, vecs[i].b, 0, vecs[i].pop);
            step();
            check($sformatf("vec%0d_count", i),     32'(count),       32'(vecs[i].exp_count));
            check($sformatf("vec%0d_rd_valid", i),  32'(rd_valid),    32'(vecs[i].exp_valid));
            check($sformatf("vec%0d_rd_data", i),   32'(rd_data),     32'(vecs[i].exp_data));
            check($sformatf("vec%0d_overrun", i),   32'(overrun),     32'(vecs[i].exp_ovr));
            check($sformatf("vec%0d_rec_ready", i), 32'(rec_ready_o), 32'(vecs[i].exp_rr));
        end
        apply_stimulus(1, 0, 0, 8'h00, 0, 0);

        // Push while full with a pop landing on the same write cycle.
        for (int i = 1; i <= 4; i++) push_byte(8'(i), 0);
        check("full_count", 32'(count), 32'd4);
        rx_ready_i = 1'b1;
        rx_byte_i  = 8'hA5;
        step();
        rx_ready_i = 1'b0;
        pop        = 1'b1;
        step();
        pop = 1'b0;
        check("pp_count",   32'(count),   32'd4);
        check("pp_head",    32'(rd_data), 32'h02);
        check("pp_overrun", 32'(overrun), 32'd0);
        exp_q = '{8'h02, 8'h03, 8'h04, 8'hA5};
        for (int i = 0; i < 4; i++) begin
            check($sformatf("pp_order%0d", i), 32'(rd_data), 32'(exp_q[i]));
            do_pop();
        end
        check("pp_empty", 32'(rd_valid), 32'd0);

        // Parity errors, then saturation of the error counter.
        clr = 1'b1;
        step();
        clr = 1'b0;
        push_byte(8'h10, 1);
        push_byte(8'h11, 0);
        push_byte(8'h12, 1);
        push_byte(8'h13, 1);
        check("par_err_count", 32'(err_count), 32'd3);
        exp_e = '{1'b1, 1'b0, 1'b1, 1'b1};
        exp_q = '{8'h10, 8'h11, 8'h12, 8'h13};
        for (int i = 0; i < 4; i++) begin
            check($sformatf("par_rd_err%0d", i),  32'(rd_err),  32'(exp_e[i]));
            check($sformatf("par_rd_data%0d", i), 32'(rd_data), 32'(exp_q[i]));
            do_pop();
        end
        for (int i = 0; i < 260; i++) push_byte(8'(i), 1);
        check("sat_err_count", 32'(err_count), 32'd255);
        check("sat_overrun",   32'(overrun),   32'd1);
        check("sat_count",     32'(count),     32'd4);
        clr = 1'b1;
        step();
        clr = 1'b0;
        check("clr_err_count", 32'(err_count), 32'd0);
        check("clr_overrun",   32'(overrun),   32'd0);
        check("clr_count",     32'(count),     32'd0);

        // Asynchronous reset with bytes stored.
        step();
        step();
        push_byte(8'h31, 0);
        push_byte(8'h32, 1);
        check("pre_reset_count", 32'(count), 32'd2);
        @(posedge clk);
        model_edge();
        #3 nRst = 1'b0;
        model_reset();
        #1;
        check_reset_values("async_reset");
        @(negedge clk);
        @(posedge clk);
        model_edge();
        #1;
        nRst = 1'b1;
        en   = 1'b0;
        repeat (2) step();
        check("rel_rec_ready_idle", 32'(rec_ready_o), 32'd0);
        check("rel_count",          32'(count),       32'd0);
        en = 1'b1;
        step();
        check("rel_rec_ready_lag", 32'(rec_ready_o), 32'd0);
        step();
        check("rel_rec_ready", 32'(rec_ready_o), 32'd1);

        // Idle timeout: first pulse and the periodic repeat.
        push_byte(8'h77, 0);
        check("to_count", 32'(count), 32'd1);
        k = 0;
        while (k < TO + 500) begin
            step();
            k++;
            if (timeout) break;
        end
        check("to_first_delay", 32'(k), 32'(TO));
        step();
        check("to_one_cycle", 32'(timeout), 32'd0);
        k = 1;
        while (k < TO + 500) begin
            step();
            k++;
            if (timeout) break;
        end
        check("to_period", 32'(k), 32'(TO));
        do_pop();

        // A pop before the limit means no pulse.
        push_byte(8'h78, 0);
        saw = 0;
        for (int i = 0; i < TO - 500; i++) begin
            step();
            if (timeout) saw = 1;
        end
        do_pop();
        for (int i = 0; i < 1000; i++) begin
            step();
            if (timeout) saw = 1;
        end
        check("to_pop_suppress", 32'(saw), 32'd0);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 3000; i++) begin
            apply_stimulus($urandom_range(0, 9) != 0,
                           $urandom_range(0, 99) == 0,
                           1'($urandom_range(0, 1)),
                           8'($urandom),
                           $urandom_range(0, 3) == 0,
                           $urandom_range(0, 4) == 0);
            step();
            check_output();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
